// File: rtl/reg_dest_scoreboard_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_dest_scoreboard_if : issue / writeback / operand-lookup bundle. rev 1.0
// ---------------------------------------------------------------------------
interface reg_dest_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
);
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_dest;
  logic              iss_ready;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_dest;
  logic [NREG-1:0]   wb_we_onehot;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rs_busy;
  logic              rt_busy;
  logic              stall;
  logic              idle;
  logic              wb_err;

  modport master (
    output iss_valid, iss_dest, wb_valid, wb_dest, rs_addr, rt_addr,
    input  iss_ready, wb_we_onehot, rs_busy, rt_busy, stall, idle, wb_err
  );

  modport slave (
    input  iss_valid, iss_dest, wb_valid, wb_dest, rs_addr, rt_addr,
    output iss_ready, wb_we_onehot, rs_busy, rt_busy, stall, idle, wb_err
  );
endinterface
`default_nettype wire

// File: rtl/reg_dest_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_dest_scoreboard : per-GPR outstanding-write counters, hazard flags and
// registered one-hot regfile write enable.                          rev 1.0
// ---------------------------------------------------------------------------
module reg_dest_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_dest_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] C_MAX     = '1;
  localparam logic [NREG-1:0]  C_ONE     = NREG'(1);
  localparam logic [NREG-1:0]  C_TRACKED = ~C_ONE;

  logic [CNT_W-1:0] r_cnt     [NREG];
  logic [CNT_W-1:0] w_cnt_nxt [NREG];
  logic [NREG-1:0]  r_we_onehot;
  logic             r_wb_err;

  logic [NREG-1:0]  w_nz;
  logic [NREG-1:0]  w_iss_sel;
  logic [NREG-1:0]  w_wb_sel;
  logic             w_iss_sat;
  logic             w_wb_same;
  logic             w_iss_ready;
  logic             w_iss_fire;
  logic             w_err_set;

  always_comb begin
    w_nz = '0;
    for (int r = 1; r < NREG; r++) begin
      w_nz[r] = (r_cnt[r] != '0);
    end
  end

  // A retire of the same register frees the slot a saturated issue needs.
  assign w_iss_sat   = (sb.iss_dest != '0) && (r_cnt[sb.iss_dest] == C_MAX);
  assign w_wb_same   = sb.wb_valid && (sb.wb_dest == sb.iss_dest);
  assign w_iss_ready = !(w_iss_sat && !w_wb_same);
  assign w_iss_fire  = sb.iss_valid && w_iss_ready;

  // Register 0 is masked out of both decodes so it is never counted.
  assign w_iss_sel = w_iss_fire  ? ((C_ONE << sb.iss_dest) & C_TRACKED) : '0;
  assign w_wb_sel  = sb.wb_valid ? ((C_ONE << sb.wb_dest)  & C_TRACKED) : '0;

  // Retiring an idle register is an error unless an issue covers it this cycle.
  assign w_err_set = |(w_wb_sel & ~w_nz & ~w_iss_sel);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      if (w_iss_sel[r] && !w_wb_sel[r]) begin
        w_cnt_nxt[r] = r_cnt[r] + CNT_W'(1);
      end else if (!w_iss_sel[r] && w_wb_sel[r] && w_nz[r]) begin
        w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
      r_we_onehot <= '0;
      r_wb_err    <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
      r_we_onehot <= w_wb_sel;
      r_wb_err    <= r_wb_err | w_err_set;
    end
  end

  assign sb.iss_ready    = w_iss_ready;
  assign sb.rs_busy      = w_nz[sb.rs_addr];
  assign sb.rt_busy      = w_nz[sb.rt_addr];
  assign sb.stall        = w_nz[sb.rs_addr] | w_nz[sb.rt_addr];
  assign sb.idle         = ~|w_nz;
  assign sb.wb_we_onehot = r_we_onehot;
  assign sb.wb_err       = r_wb_err;

endmodule
`default_nettype wire
